upc_checkout_station: RTL and testbench

Sequential, parametrised successor to the combinational UPC discount/stolen detector. Each scan strobe samples a UPC code and a security-mark bit. The block registers the per-item discount/stolen verdict and keeps saturating counts of items, discounted items and stolen items. A stolen verdict raises a latched alarm with a minimum hold time that only an explicit clear can end. It sits between the board switch/key inputs and the LEDR/HEX display logic in the DE1_SoC top level.

---
 rtl/upc_checkout_station.sv | 135 +++++++++++++
 tb/tb_upc_checkout_station.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/upc_checkout_station.sv
// ----------------------------------------------------------------------------
// upc_checkout_station
//
// Registered checkout station for one scanner lane. Each rising edge of the
// scan level accepts one item. For that item the block registers:
//   discount : the UPC is on the discount list
//   stolen   : the UPC is expensive and carries no security mark
// It also keeps saturating counts of items, discounted items and stolen items.
// A stolen item latches an alarm. The alarm stays up for at least ALARM_HOLD
// cycles, and only the operator clear can end it. Scans are ignored while the
// alarm is up.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   upc            UPC code of the item being scanned
//   mark           security mark present (1 = marked/paid)
//   scan           scan level, already synchronised; a 0->1 step scans an item
//   clear_alarm    operator alarm clear, level-sensitive
//   discount       discount verdict of the last accepted item
//   stolen         stolen verdict of the last accepted item
//   alarm          latched alarm
//   busy           high while the alarm is active (scans ignored)
//   last_upc       UPC code of the last accepted item
//   item_count     accepted items, saturating
//   discount_count accepted discounted items, saturating
//   stolen_count   accepted stolen items, saturating
// ----------------------------------------------------------------------------
module upc_checkout_station #(
  parameter int                   UPC_W          = 3,
  parameter int                   CNT_W          = 8,
  parameter int                   ALARM_HOLD     = 4,
  parameter logic [2**UPC_W-1:0]  DISCOUNT_MASK  = 8'hA6,
  parameter logic [2**UPC_W-1:0]  EXPENSIVE_MASK = 8'h53
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [UPC_W-1:0] upc,
  input  logic             mark,
  input  logic             scan,
  input  logic             clear_alarm,
  output logic             discount,
  output logic             stolen,
  output logic             alarm,
  output logic             busy,
  output logic [UPC_W-1:0] last_upc,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] discount_count,
  output logic [CNT_W-1:0] stolen_count
);

  // The hold counter only has to reach ALARM_HOLD-1.
  localparam int                HOLD_W    = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ALARM_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ALARM = 1'b1
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold;
  logic              scan_q;
  logic              scan_edge;
  logic              d_now;
  logic              s_now;

  // Verdicts for the item currently in front of the scanner.
  assign d_now     = DISCOUNT_MASK[upc];
  assign s_now     = EXPENSIVE_MASK[upc] & ~mark;
  assign scan_edge = scan & ~scan_q;
  assign busy      = (state == S_ALARM);

  // The counters stop at their maximum. They never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic             inc);
    return (inc && (value != {CNT_W{1'b1}})) ? value + CNT_W'(1) : value;
  endfunction

  // NOTE: all state in this block uses non-blocking assignments. Every
  // register then samples the values from before the edge. That is what lets
  // scan_q and the FSM see the same scan_edge in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: scan_q takes the live scan level during reset and is not
      // cleared. If scan is held high through reset, the first cycle after
      // reset then sees no edge.
      scan_q         <= scan;
      state          <= S_IDLE;
      hold           <= '0;
      alarm          <= 1'b0;
      discount       <= 1'b0;
      stolen         <= 1'b0;
      last_upc       <= '0;
      item_count     <= '0;
      discount_count <= '0;
      stolen_count   <= '0;
    end else begin
      scan_q <= scan;
      case (state)
        S_IDLE: begin
          if (scan_edge) begin
            discount       <= d_now;
            stolen         <= s_now;
            last_upc       <= upc;
            item_count     <= sat_inc(item_count, 1'b1);
            discount_count <= sat_inc(discount_count, d_now);
            stolen_count   <= sat_inc(stolen_count, s_now);
            if (s_now) begin
              state <= S_ALARM;
              alarm <= 1'b1;
              hold  <= HOLD_INIT;
            end
          end
        end
        S_ALARM: begin
          // Scan edges are dropped here. That includes an edge in the same
          // cycle as an honoured clear, so the next item needs a fresh edge.
          if (clear_alarm && (hold == '0)) begin
            state <= S_IDLE;
            alarm <= 1'b0;
          end else if (hold != '0) begin
            hold <= hold - HOLD_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          alarm <= 1'b0;
          hold  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upc_checkout_station.sv
// ----------------------------------------------------------------------------
// tb_upc_checkout_station
//
// Directed bench for upc_checkout_station. It uses two instances:
//   dut : default parameters (CNT_W=8, ALARM_HOLD=4)
//   sat : CNT_W=2, ALARM_HOLD=1, to exercise counter saturation and a
//         clear that is honoured from the very first alarm cycle
// Both instances share clk and reset. Inputs change #1 after a rising edge,
// and outputs are sampled at that same point.
// Lookup masks: discount 8'hA6 -> UPCs 1,2,5,7; expensive 8'h53 -> UPCs 0,1,4,6.
// ----------------------------------------------------------------------------
module tb_upc_checkout_station;

  logic       clk = 1'b0;
  logic       reset;

  // Main instance signals.
  logic [2:0] upc;
  logic       mark;
  logic       scan;
  logic       clear_alarm;
  logic       discount;
  logic       stolen;
  logic       alarm;
  logic       busy;
  logic [2:0] last_upc;
  logic [7:0] item_count;
  logic [7:0] discount_count;
  logic [7:0] stolen_count;

  // Saturation instance signals.
  logic [2:0] s_upc;
  logic       s_mark;
  logic       s_scan;
  logic       s_clear;
  logic       s_discount;
  logic       s_stolen;
  logic       s_alarm;
  logic       s_busy;
  logic [2:0] s_last_upc;
  logic [1:0] s_item_count;
  logic [1:0] s_discount_count;
  logic [1:0] s_stolen_count;

  int n_checks = 0;
  int n_fails  = 0;
  int n_alarm;

  always #5 clk = ~clk;

  upc_checkout_station dut (
    .clk            (clk),
    .reset          (reset),
    .upc            (upc),
    .mark           (mark),
    .scan           (scan),
    .clear_alarm    (clear_alarm),
    .discount       (discount),
    .stolen         (stolen),
    .alarm          (alarm),
    .busy           (busy),
    .last_upc       (last_upc),
    .item_count     (item_count),
    .discount_count (discount_count),
    .stolen_count   (stolen_count)
  );

  upc_checkout_station #(.CNT_W(2), .ALARM_HOLD(1)) sat (
    .clk            (clk),
    .reset          (reset),
    .upc            (s_upc),
    .mark           (s_mark),
    .scan           (s_scan),
    .clear_alarm    (s_clear),
    .discount       (s_discount),
    .stolen         (s_stolen),
    .alarm          (s_alarm),
    .busy           (s_busy),
    .last_upc       (s_last_upc),
    .item_count     (s_item_count),
    .discount_count (s_discount_count),
    .stolen_count   (s_stolen_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks the full visible state of the main instance.
  task automatic check_main(input string tag, input logic d, input logic s,
                            input logic a, input logic [2:0] lu,
                            input logic [7:0] ic, input logic [7:0] dc,
                            input logic [7:0] sc);
    check({tag, ".discount"}, 32'(discount), 32'(d));
    check({tag, ".stolen"},   32'(stolen),   32'(s));
    check({tag, ".alarm"},    32'(alarm),    32'(a));
    check({tag, ".busy"},     32'(busy),     32'(a));
    check({tag, ".last_upc"}, 32'(last_upc), 32'(lu));
    check({tag, ".items"},    32'(item_count),     32'(ic));
    check({tag, ".discs"},    32'(discount_count), 32'(dc));
    check({tag, ".stolens"},  32'(stolen_count),   32'(sc));
  endtask

  initial begin
    reset = 1'b1; upc = '0; mark = 1'b0; scan = 1'b0; clear_alarm = 1'b0;
    s_upc = '0; s_mark = 1'b0; s_scan = 1'b0; s_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_main("reset", 0, 0, 0, 3'd0, 8'd0, 8'd0, 8'd0);

    // 1: UPC 2 is discounted and not expensive.
    upc = 3'd2; mark = 1'b0; scan = 1'b1;
    tick();
    check_main("t1", 1, 0, 0, 3'd2, 8'd1, 8'd1, 8'd0);
    scan = 1'b0;
    tick();

    // 2: UPC 1 unmarked is stolen. Clear is held from the next cycle, and
    //    the alarm must stay up for exactly 4 cycles.
    upc = 3'd1; mark = 1'b0; scan = 1'b1;
    tick();
    check_main("t2", 1, 1, 1, 3'd1, 8'd2, 8'd2, 8'd1);
    scan = 1'b0; clear_alarm = 1'b1;
    n_alarm = 1;
    while (alarm && n_alarm < 20) begin
      tick();
      if (alarm) n_alarm++;
    end
    check("t2.alarm_cycles", 32'(n_alarm), 32'd4);
    check("t2.idle_busy", 32'(busy), 32'd0);
    clear_alarm = 1'b0;
    tick();

    // 3: re-enter the alarm with UPC 1, then give three ignored scans of UPC 5.
    upc = 3'd1; mark = 1'b0; scan = 1'b1;
    tick();
    check_main("t3.enter", 1, 1, 1, 3'd1, 8'd3, 8'd3, 8'd2);
    scan = 1'b0;
    tick();
    upc = 3'd5; mark = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scan = 1'b1; tick();
      scan = 1'b0; tick();
    end
    check_main("t3.ignored", 1, 1, 1, 3'd1, 8'd3, 8'd3, 8'd2);
    // The scan edge coincides with the honoured clear, so it is dropped.
    // Holding scan high afterwards must not count an item either.
    scan = 1'b1; clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    check("t3.cleared", 32'(alarm), 32'd0);
    tick(); tick();
    check_main("t3.held", 1, 1, 0, 3'd1, 8'd3, 8'd3, 8'd2);
    scan = 1'b0;
    tick();
    scan = 1'b1;
    tick();
    check_main("t3.fresh", 1, 0, 0, 3'd5, 8'd4, 8'd4, 8'd2);
    scan = 1'b0;
    tick();

    // 4: UPC 0 is expensive but not discounted. Marked is fine; unmarked
    //    raises the alarm.
    upc = 3'd0; mark = 1'b1; scan = 1'b1;
    tick();
    check_main("t4.marked", 0, 0, 0, 3'd0, 8'd5, 8'd4, 8'd2);
    scan = 1'b0;
    tick();
    mark = 1'b0; scan = 1'b1;
    tick();
    check_main("t4.unmarked", 0, 1, 1, 3'd0, 8'd6, 8'd4, 8'd3);

    // 6: reset in the middle of the alarm while scan is held high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_main("t6.reset", 0, 0, 0, 3'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("t6.held_items", 32'(item_count), 32'd0);
    scan = 1'b0;
    tick();
    upc = 3'd2; mark = 1'b0; scan = 1'b1;
    tick();
    check_main("t6.rescan", 1, 0, 0, 3'd2, 8'd1, 8'd1, 8'd0);
    scan = 1'b0;
    tick();

    // 5: with CNT_W=2 the counters saturate at 3 after five UPC 7 scans.
    s_upc = 3'd7; s_mark = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      s_scan = 1'b1; tick();
      check($sformatf("t5.items%0d", k), 32'(s_item_count), (k < 3) ? k : 3);
      check($sformatf("t5.discs%0d", k), 32'(s_discount_count), (k < 3) ? k : 3);
      check($sformatf("t5.stolen%0d", k), 32'(s_stolen_count), 32'd0);
      s_scan = 1'b0; tick();
    end

    // ALARM_HOLD=1: a clear held from entry ends the alarm after one cycle.
    // The stolen counter still advances while the item counter is saturated.
    s_upc = 3'd1; s_mark = 1'b0; s_clear = 1'b1; s_scan = 1'b1;
    tick();
    check("hold1.alarm_on", 32'(s_alarm), 32'd1);
    check("hold1.stolen_cnt", 32'(s_stolen_count), 32'd1);
    check("hold1.items_sat", 32'(s_item_count), 32'd3);
    s_scan = 1'b0;
    tick();
    check("hold1.alarm_off", 32'(s_alarm), 32'd0);
    check("hold1.busy_off", 32'(s_busy), 32'd0);
    s_clear = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
